led_pattern_seq: RTL

- Downstream consumer of the half-second blink counter's slow square-wave LED output.
- Edge-detects that square wave and uses each detected edge as a step tick.
- Steps a selectable LED pattern (off, running light, ping-pong, binary count) across a small LED bank.
- Drives the board LED pins directly. Also reports step and pattern-wrap pulses for status logic.

---
 rtl/led_pattern_seq_if.sv | 22 ++
 rtl/led_pattern_seq.sv | 106 ++++++++++
 2 files changed

// File: rtl/led_pattern_seq_if.sv
// Pattern sequencer bus: tick/mode/pause toward the sequencer, LED and status pulses back.
// No backpressure; outputs change only on the clock edge after an applied tick transition.
interface led_pattern_seq_if #(
    parameter int N_LED = 4
) ();
    logic             tick_in;
    logic [1:0]       mode;
    logic             pause;
    logic [N_LED-1:0] led;
    logic             step_pulse;
    logic             wrap;

    modport master (
        output tick_in, mode, pause,
        input  led, step_pulse, wrap
    );

    modport slave (
        input  tick_in, mode, pause,
        output led, step_pulse, wrap
    );
endinterface

// File: rtl/led_pattern_seq.sv
// Steps an LED pattern on each edge of a slow tick; led/step_pulse/wrap register one cycle after the tick change.
// No backpressure: a step arriving while paused is dropped, never queued.
module led_pattern_seq #(
    parameter int N_LED          = 4,
    parameter bit BOTH_EDGES     = 1'b1,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic              Clk50M,
    input  logic              Rst,
    led_pattern_seq_if.slave  bus
);
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [N_LED-1:0] PAT_ZERO = {N_LED{1'b0}};
    localparam logic [N_LED-1:0] PAT_ONE  = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] LED_RST  = LED_ACTIVE_LOW ? {N_LED{1'b1}} : {N_LED{1'b0}};

    logic             tick_q;
    logic [N_LED-1:0] pattern_q, pattern_d;
    dir_t             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             step_pulse_q, step_pulse_d;
    logic             wrap_q, wrap_d;
    logic             step;
    logic             step_apply;

    // tick_q resets high to match the blink counter, so reset release creates no edge
    assign step       = BOTH_EDGES ? (bus.tick_in ^ tick_q) : (bus.tick_in & ~tick_q);
    assign step_apply = step & ~bus.pause;

    always_ff @(posedge Clk50M or posedge Rst) begin
        if (Rst) begin
            tick_q       <= 1'b1;
            pattern_q    <= PAT_ZERO;
            dir_q        <= DIR_UP;
            mode_q       <= 2'd0;
            led_q        <= LED_RST;
            step_pulse_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            tick_q       <= bus.tick_in;
            pattern_q    <= pattern_d;
            dir_q        <= dir_d;
            mode_q       <= mode_d;
            led_q        <= led_d;
            step_pulse_q <= step_pulse_d;
            wrap_q       <= wrap_d;
        end
    end

    always_comb begin
        pattern_d    = pattern_q;
        dir_d        = dir_q;
        mode_d       = mode_q;
        step_pulse_d = 1'b0;
        wrap_d       = 1'b0;

        if (step_apply) begin
            step_pulse_d = 1'b1;
            if (bus.mode != mode_q) begin
                // A new mode restarts from its own start value instead of advancing
                mode_d    = bus.mode;
                dir_d     = DIR_UP;
                pattern_d = ((bus.mode == 2'd1) || (bus.mode == 2'd2)) ? PAT_ONE : PAT_ZERO;
            end else begin
                case (mode_q)
                    2'd1: begin
                        pattern_d = {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
                        wrap_d    = pattern_q[N_LED-1];
                    end
                    2'd2: begin
                        if (dir_q == DIR_UP) begin
                            pattern_d = {pattern_q[N_LED-2:0], 1'b0};
                            if (pattern_d[N_LED-1]) begin
                                dir_d = DIR_DOWN;
                            end
                        end else begin
                            pattern_d = {1'b0, pattern_q[N_LED-1:1]};
                            if (pattern_d[0]) begin
                                dir_d  = DIR_UP;
                                wrap_d = 1'b1;
                            end
                        end
                    end
                    2'd3: begin
                        pattern_d = pattern_q + PAT_ONE;
                        wrap_d    = &pattern_q;
                    end
                    default: begin
                        pattern_d = PAT_ZERO;
                    end
                endcase
            end
        end

        led_d = LED_ACTIVE_LOW ? ~pattern_d : pattern_d;
    end

    assign bus.led        = led_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.wrap       = wrap_q;
endmodule
